// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one 2:1 mux into a registered
// output stage, with saturating per-source transfer counters.
module mux2_rr_arbiter #(
   parameter int N  = 4,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_valid,
   input  logic [N-1:0]  a_data,
   output logic          a_ready,
   input  logic          b_valid,
   input  logic [N-1:0]  b_data,
   output logic          b_ready,
   output logic          out_valid,
   output logic [N-1:0]  out_data,
   output logic          out_src,
   input  logic          out_ready,
   output logic [CW-1:0] cnt_a,
   output logic [CW-1:0] cnt_b
);

   logic          last_grant;
   logic          load_en;
   logic          grant_a;
   logic          grant_b;
   logic          xfer;
   logic [N-1:0]  mux_out;

   // last_grant: 0 = A served last, 1 = B served last
   assign grant_a = a_valid && (!b_valid || last_grant);
   assign grant_b = b_valid && (!a_valid || !last_grant);

   assign load_en = !out_valid || out_ready;
   assign mux_out = grant_b ? b_data : a_data;

   assign a_ready = !reset && load_en && grant_a;
   assign b_ready = !reset && load_en && grant_b;
   assign xfer    = a_ready || b_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= 1'b0;
         last_grant <= 1'b1;
         cnt_a      <= '0;
         cnt_b      <= '0;
      end else if (xfer) begin
         out_valid  <= 1'b1;
         out_data   <= mux_out;
         out_src    <= grant_b;
         last_grant <= grant_b;
         if (grant_a && cnt_a != '1)
            cnt_a <= cnt_a + 1'b1;
         if (grant_b && cnt_b != '1)
            cnt_b <= cnt_b + 1'b1;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: handshake, fairness, stall,
// withdrawn request, counter saturation and asynchronous reset.
module tb_mux2_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_valid, b_valid, out_ready;
   logic [3:0] a_data, b_data;

   logic       a_ready, b_ready, out_valid, out_src;
   logic [3:0] out_data;
   logic [7:0] cnt_a, cnt_b;

   logic       s_a_ready, s_b_ready, s_out_valid, s_out_src;
   logic [3:0] s_out_data;
   logic [1:0] s_cnt_a, s_cnt_b;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mux2_rr_arbiter #(.N(4), .CW(8)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   mux2_rr_arbiter #(.N(4), .CW(2)) dut_sat (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_data(a_data), .a_ready(s_a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(s_b_ready),
      .out_valid(s_out_valid), .out_data(s_out_data), .out_src(s_out_src),
      .out_ready(out_ready), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1;
      a_data = 4'h0; b_data = 4'h0;
      out_ready = 1'b1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_cnt_b", cnt_b, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      tick();
      reset = 1'b0;

      // single A transfer
      a_valid = 1'b1; a_data = 4'h5; b_valid = 1'b0;
      #1;
      chk("t1_a_ready", a_ready, 1);
      chk("t1_b_ready", b_ready, 0);
      tick();
      a_valid = 1'b0;
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_data", out_data, 4'h5);
      chk("t1_out_src", out_src, 0);
      chk("t1_cnt_a", cnt_a, 1);
      tick();
      chk("t1_drain_valid", out_valid, 0);
      chk("t1_drain_data", out_data, 4'h5);

      // fairness
      do_reset();
      a_valid = 1'b1; a_data = 4'hA;
      b_valid = 1'b1; b_data = 4'hB;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_a_ready", a_ready, (k % 2 == 0));
         chk("rr_b_ready", b_ready, (k % 2 == 1));
         tick();
         chk("rr_out_valid", out_valid, 1);
         chk("rr_out_data", out_data, (k % 2 == 0) ? 4'hA : 4'hB);
         chk("rr_out_src", out_src, (k % 2 == 1));
      end
      chk("rr_cnt_a", cnt_a, 3);
      chk("rr_cnt_b", cnt_b, 3);

      // load 3 from A (B was served last)
      a_data = 4'h3; b_valid = 1'b0;
      tick();
      chk("st_load_data", out_data, 4'h3);
      chk("st_load_src", out_src, 0);
      chk("st_cnt_a", cnt_a, 4);

      // withdrawn B request during stall
      out_ready = 1'b0; a_valid = 1'b0;
      b_valid = 1'b1; b_data = 4'h9;
      #1;
      chk("wd_b_ready", b_ready, 0);
      tick();
      b_valid = 1'b0;
      tick();
      chk("wd_cnt_b", cnt_b, 3);
      chk("wd_out_src", out_src, 0);
      chk("wd_out_data", out_data, 4'h3);
      chk("wd_out_valid", out_valid, 1);

      // stall with both valid
      a_valid = 1'b1; a_data = 4'h4;
      b_valid = 1'b1; b_data = 4'h7;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("st_a_ready", a_ready, 0);
         chk("st_b_ready", b_ready, 0);
         tick();
         chk("st_hold_valid", out_valid, 1);
         chk("st_hold_data", out_data, 4'h3);
         chk("st_hold_src", out_src, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("st_rel_b_ready", b_ready, 1);
      chk("st_rel_a_ready", a_ready, 0);
      tick();
      chk("st_rel_valid", out_valid, 1);
      chk("st_rel_data", out_data, 4'h7);
      chk("st_rel_src", out_src, 1);
      chk("st_rel_cnt_b", cnt_b, 4);

      // saturation on the CW=2 instance
      do_reset();
      a_valid = 1'b1; a_data = 4'h1; b_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("sat_cnt_a", s_cnt_a, (k > 3) ? 3 : k);
         chk("sat_cnt_b", s_cnt_b, 0);
         chk("wide_cnt_a", cnt_a, k);
      end

      // asynchronous reset between edges
      chk("ar_pre_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_cnt_a", cnt_a, 0);
      chk("ar_cnt_b", cnt_b, 0);
      chk("ar_a_ready", a_ready, 0);
      tick();
      reset = 1'b0;
      a_valid = 1'b1; a_data = 4'h1;
      b_valid = 1'b1; b_data = 4'h2;
      #1;
      chk("ar_first_a_ready", a_ready, 1);
      chk("ar_first_b_ready", b_ready, 0);
      tick();
      chk("ar_first_data", out_data, 4'h1);
      chk("ar_first_src", out_src, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
